// File: rtl/store_buffer.sv
// store_buffer -- MEM-stage store path with a small write FIFO.
//
// Encodes word/half/byte stores into per-byte enables and lane-shifted write
// data, rejects misaligned stores with an AdES flag, and queues aligned stores
// in a DEPTH-entry FIFO that drains to the data bus over valid/ready.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high, clears pointers, count and storage
//   req_valid   pipeline presents a store this cycle
//   req_op      000 none, 001 sw, 010 sh, 011 sb, others none
//   req_addr    byte address
//   req_data    store data (sh uses [15:0], sb uses [7:0])
//   req_ready   FIFO not full
//   exc_ades    misaligned store presented this cycle (combinational)
//   bus_valid   head entry valid
//   bus_addr    head entry word address (low 2 bits zero)
//   bus_byteen  head entry byte enables
//   bus_wdata   head entry lane-shifted data
//   bus_ready   bus accepts head entry
//   busy        FIFO not empty
module store_buffer #(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   input  logic [2:0]    req_op,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_data,
   output logic          req_ready,
   output logic          exc_ades,
   output logic          bus_valid,
   output logic [AW-1:0] bus_addr,
   output logic [3:0]    bus_byteen,
   output logic [31:0]   bus_wdata,
   input  logic          bus_ready,
   output logic          busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [2:0] OP_SW = 3'b001;
   localparam logic [2:0] OP_SH = 3'b010;
   localparam logic [2:0] OP_SB = 3'b011;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic [AW-1:0] mem_addr  [DEPTH];
   logic [3:0]    mem_be    [DEPTH];
   logic [31:0]   mem_wdata [DEPTH];

   logic          full;
   logic          empty;
   logic          is_store;
   logic          misaligned;
   logic          enq;
   logic          deq;
   logic [3:0]    enc_be;
   logic [31:0]   enc_wdata;
   logic [AW-1:0] enc_addr;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   assign is_store   = (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);
   assign misaligned = ((req_op == OP_SW) && (req_addr[1:0] != 2'b00)) ||
                       ((req_op == OP_SH) && req_addr[0]);

   // Misaligned stores raise AdES whether or not the FIFO has room.
   assign exc_ades = req_valid && misaligned;
   assign enq      = req_valid && is_store && !misaligned && !full;
   assign deq      = !empty && bus_ready;

   // req_ready depends only on registered count, never on bus_ready.
   assign req_ready = !full;
   assign busy      = !empty;
   assign bus_valid = !empty;

   assign enc_addr = {req_addr[AW-1:2], 2'b00};

   always_comb begin
      enc_be    = 4'b0000;
      enc_wdata = 32'h0;
      case (req_op)
         OP_SW: begin
            enc_be    = 4'b1111;
            enc_wdata = req_data;
         end
         OP_SH: begin
            if (req_addr[1]) begin
               enc_be    = 4'b1100;
               enc_wdata = {req_data[15:0], 16'h0};
            end else begin
               enc_be    = 4'b0011;
               enc_wdata = {16'h0, req_data[15:0]};
            end
         end
         OP_SB: begin
            enc_be    = 4'b0001 << req_addr[1:0];
            enc_wdata = {24'h0, req_data[7:0]} << {req_addr[1:0], 3'b000};
         end
         default: begin
            enc_be    = 4'b0000;
            enc_wdata = 32'h0;
         end
      endcase
   end

   // FIFO state: pointers wrap modulo DEPTH (power of two).
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr[i]  <= '0;
            mem_be[i]    <= '0;
            mem_wdata[i] <= '0;
         end
      end else begin
         if (enq) begin
            mem_addr[wr_ptr]  <= enc_addr;
            mem_be[wr_ptr]    <= enc_be;
            mem_wdata[wr_ptr] <= enc_wdata;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (enq && !deq) begin
            count <= count + 1'b1;
         end else if (deq && !enq) begin
            count <= count - 1'b1;
         end
      end
   end

   // Head entry drives the bus straight from storage; stable until dequeued.
   assign bus_addr   = mem_addr[rd_ptr];
   assign bus_byteen = mem_be[rd_ptr];
   assign bus_wdata  = mem_wdata[rd_ptr];

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer -- directed, table-driven bench for store_buffer.
module tb_store_buffer;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        req_ready;
   logic        exc_ades;
   logic        bus_valid;
   logic [31:0] bus_addr;
   logic [3:0]  bus_byteen;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic        busy;

   int n_cmp;
   int n_err;

   store_buffer #(.DEPTH(2), .AW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .exc_ades   (exc_ades),
      .bus_valid  (bus_valid),
      .bus_addr   (bus_addr),
      .bus_byteen (bus_byteen),
      .bus_wdata  (bus_wdata),
      .bus_ready  (bus_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic        ades;
      logic        acc;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] baddr;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      req_valid = v;
      req_op    = op;
      req_addr  = a;
      req_data  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus_ready = 1'b0;
      drive(1'b0, 3'b000, 32'h0, 32'h0);

      //                vld  op      addr          data          ades acc be       wd            baddr
      vecs[0]  = '{1'b1, 3'b001, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1004};
      vecs[1]  = '{1'b1, 3'b010, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 1'b1, 4'b1100, 32'hABCD_0000, 32'h0000_2000};
      vecs[2]  = '{1'b1, 3'b011, 32'h0000_2003, 32'h0000_0055, 1'b0, 1'b1, 4'b1000, 32'h5500_0000, 32'h0000_2000};
      vecs[3]  = '{1'b1, 3'b010, 32'h0000_2000, 32'h1234_ABCD, 1'b0, 1'b1, 4'b0011, 32'h0000_ABCD, 32'h0000_2000};
      vecs[4]  = '{1'b1, 3'b011, 32'h0000_2001, 32'hAABB_CC77, 1'b0, 1'b1, 4'b0010, 32'h0000_7700, 32'h0000_2000};
      vecs[5]  = '{1'b1, 3'b011, 32'h0000_2002, 32'hAABB_CC77, 1'b0, 1'b1, 4'b0100, 32'h0077_0000, 32'h0000_2000};
      vecs[6]  = '{1'b1, 3'b011, 32'h0000_2000, 32'hAABB_CC77, 1'b0, 1'b1, 4'b0001, 32'h0000_0077, 32'h0000_2000};
      vecs[7]  = '{1'b1, 3'b001, 32'h0000_3001, 32'h1111_1111, 1'b1, 1'b0, 4'b0000, 32'h0,          32'h0};
      vecs[8]  = '{1'b1, 3'b010, 32'h0000_3003, 32'h2222_2222, 1'b1, 1'b0, 4'b0000, 32'h0,          32'h0};
      vecs[9]  = '{1'b1, 3'b010, 32'h0000_3001, 32'h2222_2222, 1'b1, 1'b0, 4'b0000, 32'h0,          32'h0};
      vecs[10] = '{1'b1, 3'b000, 32'h0000_3001, 32'h3333_3333, 1'b0, 1'b0, 4'b0000, 32'h0,          32'h0};
      vecs[11] = '{1'b1, 3'b101, 32'h0000_3001, 32'h3333_3333, 1'b0, 1'b0, 4'b0000, 32'h0,          32'h0};
      vecs[12] = '{1'b0, 3'b001, 32'h0000_3002, 32'h4444_4444, 1'b0, 1'b0, 4'b0000, 32'h0,          32'h0};
      vecs[13] = '{1'b1, 3'b001, 32'hFFFF_FFFC, 32'h0102_0304, 1'b0, 1'b1, 4'b1111, 32'h0102_0304, 32'hFFFF_FFFC};

      // Reset state
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_busy",      {31'h0, busy},      32'h0);
      chk("rst_bus_addr",  bus_addr,           32'h0);
      chk("rst_byteen",    {28'h0, bus_byteen}, 32'h0);
      chk("rst_wdata",     bus_wdata,          32'h0);

      // Single-store vectors, bus always ready
      bus_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].vld, vecs[i].op, vecs[i].addr, vecs[i].data);
         #1;
         chk($sformatf("v%0d_ades", i), {31'h0, exc_ades}, {31'h0, vecs[i].ades});
         chk($sformatf("v%0d_rdy", i),  {31'h0, req_ready}, 32'h1);
         @(negedge clk);
         drive(1'b0, 3'b000, 32'h0, 32'h0);
         chk($sformatf("v%0d_bvalid", i), {31'h0, bus_valid}, {31'h0, vecs[i].acc});
         if (vecs[i].acc) begin
            chk($sformatf("v%0d_baddr", i), bus_addr, vecs[i].baddr);
            chk($sformatf("v%0d_be", i),    {28'h0, bus_byteen}, {28'h0, vecs[i].be});
            chk($sformatf("v%0d_wd", i),    bus_wdata, vecs[i].wd);
            @(negedge clk);
            chk($sformatf("v%0d_busy_fall", i), {31'h0, busy}, 32'h0);
         end
      end

      // Three back-to-back sw with bus stalled; C held until room frees
      bus_ready = 1'b0;
      @(negedge clk);
      drive(1'b1, 3'b001, 32'h0000_0100, 32'hAAAA_0001);
      #1 chk("fill_a_rdy", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      drive(1'b1, 3'b001, 32'h0000_0104, 32'hBBBB_0002);
      #1 chk("fill_b_rdy", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      drive(1'b1, 3'b001, 32'h0000_0108, 32'hCCCC_0003);
      #1 chk("full_rdy", {31'h0, req_ready}, 32'h0);
      repeat (3) @(negedge clk);
      chk("hold_addr", bus_addr, 32'h0000_0100);
      chk("hold_wd",   bus_wdata, 32'hAAAA_0001);
      chk("hold_rdy",  {31'h0, req_ready}, 32'h0);
      // Deq and req in the same cycle while full: C must not be taken
      bus_ready = 1'b1;
      #1 chk("full_deq_rdy", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      chk("drain_b_addr", bus_addr, 32'h0000_0104);
      chk("drain_b_wd",   bus_wdata, 32'hBBBB_0002);
      chk("retry_rdy",    {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      chk("drain_c_valid", {31'h0, bus_valid}, 32'h1);
      chk("drain_c_addr",  bus_addr, 32'h0000_0108);
      chk("drain_c_wd",    bus_wdata, 32'hCCCC_0003);
      @(negedge clk);
      chk("drain_done_valid", {31'h0, bus_valid}, 32'h0);
      chk("drain_done_busy",  {31'h0, busy}, 32'h0);

      // Reset with two entries queued
      bus_ready = 1'b0;
      drive(1'b1, 3'b001, 32'h0000_0400, 32'h1111_0000);
      @(negedge clk);
      drive(1'b1, 3'b001, 32'h0000_0404, 32'h2222_0000);
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      chk("pre_rst_full", {31'h0, req_ready}, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_valid", {31'h0, bus_valid}, 32'h0);
      chk("mid_rst_rdy",   {31'h0, req_ready}, 32'h1);
      chk("mid_rst_busy",  {31'h0, busy}, 32'h0);
      chk("mid_rst_wd",    bus_wdata, 32'h0);
      bus_ready = 1'b1;
      drive(1'b1, 3'b011, 32'h0000_0001, 32'h0000_005A);
      @(negedge clk);
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      chk("post_rst_valid", {31'h0, bus_valid}, 32'h1);
      chk("post_rst_be",    {28'h0, bus_byteen}, 32'h2);
      chk("post_rst_wd",    bus_wdata, 32'h0000_5A00);
      chk("post_rst_addr",  bus_addr, 32'h0);
      @(negedge clk);
      chk("post_rst_busy", {31'h0, busy}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
